// File: rtl/sdr_cmd_monitor_pkg.sv
// Shared types and constants for the SDRAM command-bus monitor.
package sdr_mon_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5,
    MRS = 3'd6,
    BST = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_MODE = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // Bit positions inside err_flags.
  localparam int ERR_RD_MISS = 0;  // expected read data never driven
  localparam int ERR_SPUR    = 1;  // read data driven with nothing due
  localparam int ERR_RFSH    = 2;  // refresh interval exceeded
  localparam int ERR_MRS_CAS = 3;  // MRS programs a CAS latency other than cfg
  localparam int ERR_EARLY   = 4;  // ACT/RD/WR issued before init completes
  localparam int NUM_ERR     = 5;

  // Command decode of the raw SDRAM pins; deselect or clock-disabled is a NOP.
  function automatic cmd_e decode_cmd(input logic cs, input logic cke,
                                      input logic ras, input logic cas,
                                      input logic we);
    cmd_e c;
    c = NOP;
    if (!cs && cke) begin
      case ({ras, cas, we})
        3'b111:  c = NOP;
        3'b011:  c = ACT;
        3'b101:  c = RD;
        3'b100:  c = WR;
        3'b010:  c = PRE;
        3'b001:  c = REF;
        3'b000:  c = MRS;
        default: c = BST;
      endcase
    end
    return c;
  endfunction

  // Number of error events raised in one cycle.
  function automatic logic [2:0] count_ones(input logic [NUM_ERR-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_ERR; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sdr_cmd_monitor_if.sv
// SDRAM command bus plus the memory model's read-data drive enable.
interface sdr_cmd_monitor_if;
  logic        cke;
  logic        cs;
  logic        ras;
  logic        cas;
  logic        we;
  logic [12:0] addr;
  logic        dataout_en;

  modport master (output cke, cs, ras, cas, we, addr, dataout_en);
  modport slave  (input  cke, cs, ras, cas, we, addr, dataout_en);
endinterface

// File: rtl/sdr_rd_lat_chk.sv
// Read CAS-latency checker: one expectation bit per outstanding read,
// shifting toward index 0 where it must meet dataout_en.
module sdr_rd_lat_chk
  import sdr_mon_pkg::*;
#(
  parameter int MAX_CAS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,      // RD accepted while the device is running
  input  logic [2:0] cfg_cas,
  input  logic       dataout_en,
  output logic       rd_miss,
  output logic       rd_spur
);

  logic [MAX_CAS-1:0] pipe_q;
  logic [MAX_CAS-1:0] pipe_d;
  logic               den_q;
  logic               due;

  // Next expectation vector and the two error events for this cycle.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no path leaves it unassigned and no latch is inferred.
    pipe_d  = pipe_q >> 1;
    due     = pipe_q[0];
    rd_miss = due && !dataout_en;
    rd_spur = dataout_en && !den_q && !due;
    // A CAS setting outside 1..MAX_CAS matches no slot, so the read goes untracked.
    for (int i = 0; i < MAX_CAS; i++) begin
      if (rd_req && cfg_cas == 3'(i + 1)) pipe_d[i] = 1'b1;
    end
  end

  // Expectation pipe and previous dataout_en for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the pipe is cleared on reset; a surviving bit would report a miss for a read that reset already cancelled.
      pipe_q <= '0;
      den_q  <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      den_q  <= dataout_en;
    end
  end

endmodule

// File: rtl/sdr_cmd_monitor.sv
// SDRAM command-bus monitor: decode, init tracking, command statistics,
// refresh-interval and read-latency checking with sticky error flags.
module sdr_cmd_monitor
  import sdr_mon_pkg::*;
#(
  parameter int MAX_CAS    = 4,
  parameter int RFSH_SLACK = 64,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  sdr_cmd_monitor_if.slave    bus,
  input  logic [2:0]          cfg_sdr_cas,
  input  logic [11:0]         cfg_sdr_rfsh,
  input  logic                clr_err,
  output cmd_e                cmd,
  output state_e              mon_state,
  output logic [CNT_W-1:0]    act_cnt,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic [CNT_W-1:0]    wr_cnt,
  output logic [CNT_W-1:0]    ref_cnt,
  output logic [12:0]         rfsh_gap,
  output logic [NUM_ERR-1:0]  err_flags,
  output logic [7:0]          err_cnt
);

  localparam logic [12:0] GAP_MAX = 13'h1fff;

  cmd_e               cmd_now;
  state_e             state_q;
  state_e             state_d;
  logic               mrs_check;
  logic               rd_miss;
  logic               rd_spur;
  logic               rfsh_ovd;
  logic [12:0]        gap_d;
  logic [12:0]        rfsh_limit;
  logic [NUM_ERR-1:0] err_ev;
  logic [NUM_ERR-1:0] flags_d;
  logic [8:0]         cnt_sum;
  logic [7:0]         cnt_d;
  logic               unused_addr;

  assign cmd_now     = decode_cmd(bus.cs, bus.cke, bus.ras, bus.cas, bus.we);
  assign mon_state   = state_q;
  assign unused_addr = ^{bus.addr[12:11], bus.addr[9:7], bus.addr[3:0]};

  // Overdue threshold; 4095 + slack + 1 stays well inside 13 bits.
  assign rfsh_limit = 13'(cfg_sdr_rfsh) + 13'(RFSH_SLACK) + 13'd1;

  sdr_rd_lat_chk #(.MAX_CAS(MAX_CAS)) u_rd_lat_chk (
    .clk        (clk),
    .reset      (reset),
    .rd_req     ((cmd_now == RD) && (state_q == S_RUN)),
    .cfg_cas    (cfg_sdr_cas),
    .dataout_en (bus.dataout_en),
    .rd_miss    (rd_miss),
    .rd_spur    (rd_spur)
  );

  // Init-sequence FSM next state; flags every MRS that completes or restarts init.
  always_comb begin
    state_d   = state_q;
    mrs_check = 1'b0;
    case (state_q)
      S_INIT: if (cmd_now == PRE && bus.addr[10]) state_d = S_MODE;
      S_MODE: if (cmd_now == MRS) begin
        state_d   = S_RUN;
        mrs_check = 1'b1;
      end
      S_RUN: if (cmd_now == MRS) begin
        state_d   = S_MODE;
        mrs_check = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Refresh gap: counts enabled cycles in S_RUN, cleared by REF, pinned at 0 elsewhere.
  always_comb begin
    gap_d = rfsh_gap;
    if (state_q != S_RUN || cmd_now == REF) gap_d = '0;
    else if (bus.cke && rfsh_gap != GAP_MAX) gap_d = rfsh_gap + 13'd1;
    // Fires only on the step onto the limit, not while the gap sits there.
    rfsh_ovd = (state_q == S_RUN) && (gap_d == rfsh_limit) && (rfsh_gap != rfsh_limit);
  end

  // Error events, sticky flags and saturating event count; a new event beats clr_err.
  always_comb begin
    err_ev              = '0;
    err_ev[ERR_RD_MISS] = rd_miss;
    err_ev[ERR_SPUR]    = rd_spur;
    err_ev[ERR_RFSH]    = rfsh_ovd;
    err_ev[ERR_MRS_CAS] = mrs_check && (bus.addr[6:4] != cfg_sdr_cas);
    err_ev[ERR_EARLY]   = (state_q != S_RUN) && (cmd_now inside {ACT, RD, WR});
    flags_d = (clr_err ? '0 : err_flags) | err_ev;
    cnt_sum = {1'b0, (clr_err ? 8'd0 : err_cnt)} + 9'(count_ones(err_ev));
    cnt_d   = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
  end

  // Registered outputs: command, state, statistics and error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= NOP;
      state_q   <= S_INIT;
      act_cnt   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      ref_cnt   <= '0;
      rfsh_gap  <= '0;
      err_flags <= '0;
      err_cnt   <= '0;
    end else begin
      cmd       <= cmd_now;
      state_q   <= state_d;
      rfsh_gap  <= gap_d;
      err_flags <= flags_d;
      err_cnt   <= cnt_d;
      if (cmd_now == ACT) act_cnt <= act_cnt + CNT_W'(1);
      if (cmd_now == RD)  rd_cnt  <= rd_cnt  + CNT_W'(1);
      if (cmd_now == WR)  wr_cnt  <= wr_cnt  + CNT_W'(1);
      if (cmd_now == REF) ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Directed bench for sdr_cmd_monitor with a time-stamped expectation scoreboard.
module tb_sdr_cmd_monitor;
  import sdr_mon_pkg::*;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        cfg_sdr_cas;
  logic [11:0]       cfg_sdr_rfsh;
  logic              clr_err;
  cmd_e              cmd;
  state_e            mon_state;
  logic [CNT_W-1:0]  act_cnt, rd_cnt, wr_cnt, ref_cnt;
  logic [12:0]       rfsh_gap;
  logic [4:0]        err_flags;
  logic [7:0]        err_cnt;

  sdr_cmd_monitor_if bus_if ();

  sdr_cmd_monitor #(.MAX_CAS(4), .RFSH_SLACK(64), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .cfg_sdr_cas  (cfg_sdr_cas),
    .cfg_sdr_rfsh (cfg_sdr_rfsh),
    .clr_err      (clr_err),
    .cmd          (cmd),
    .mon_state    (mon_state),
    .act_cnt      (act_cnt),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt),
    .ref_cnt      (ref_cnt),
    .rfsh_gap     (rfsh_gap),
    .err_flags    (err_flags),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {F_CMD, F_STATE, F_ACT, F_RD, F_WR, F_REF, F_GAP, F_FLAGS, F_ECNT} field_e;

  typedef struct {
    int          due;
    field_e      f;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input field_e f);
    case (f)
      F_CMD:   return 32'(cmd);
      F_STATE: return 32'(mon_state);
      F_ACT:   return 32'(act_cnt);
      F_RD:    return 32'(rd_cnt);
      F_WR:    return 32'(wr_cnt);
      F_REF:   return 32'(ref_cnt);
      F_GAP:   return 32'(rfsh_gap);
      F_FLAGS: return 32'(err_flags);
      default: return 32'(err_cnt);
    endcase
  endfunction

  // Queue an expectation for the output state after the d-th upcoming edge.
  task automatic exp_at(input int d, input field_e f, input logic [31:0] v, input string tag);
    exp_t e;
    e.due = cyc + d;
    e.f   = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock edge, then compare every expectation that has come due.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [31:0] obs;
        obs = observe(sb[i].f);
        checks++;
        assert (obs === sb[i].val) else begin
          errors++;
          $error("FAIL %s @cyc %0d: observed %0h expected %0h", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic drive(input cmd_e c, input logic [12:0] a = '0, input logic den = 1'b0);
    bus_if.cke        = 1'b1;
    bus_if.cs         = 1'b0;
    bus_if.addr       = a;
    bus_if.dataout_en = den;
    case (c)
      ACT:     {bus_if.ras, bus_if.cas, bus_if.we} = 3'b011;
      RD:      {bus_if.ras, bus_if.cas, bus_if.we} = 3'b101;
      WR:      {bus_if.ras, bus_if.cas, bus_if.we} = 3'b100;
      PRE:     {bus_if.ras, bus_if.cas, bus_if.we} = 3'b010;
      REF:     {bus_if.ras, bus_if.cas, bus_if.we} = 3'b001;
      MRS:     {bus_if.ras, bus_if.cas, bus_if.we} = 3'b000;
      BST:     {bus_if.ras, bus_if.cas, bus_if.we} = 3'b110;
      default: {bus_if.ras, bus_if.cas, bus_if.we} = 3'b111;
    endcase
  endtask

  task automatic step(input cmd_e c, input logic [12:0] a = '0, input logic den = 1'b0);
    drive(c, a, den);
    tick();
  endtask

  task automatic exp_reset_state(input int d);
    exp_at(d, F_CMD,   NOP,    "rst_cmd");
    exp_at(d, F_STATE, S_INIT, "rst_state");
    exp_at(d, F_ACT,   0,      "rst_act");
    exp_at(d, F_RD,    0,      "rst_rd");
    exp_at(d, F_WR,    0,      "rst_wr");
    exp_at(d, F_REF,   0,      "rst_ref");
    exp_at(d, F_GAP,   0,      "rst_gap");
    exp_at(d, F_FLAGS, 0,      "rst_flags");
    exp_at(d, F_ECNT,  0,      "rst_ecnt");
  endtask

  initial begin
    reset        = 1'b1;
    clr_err      = 1'b0;
    cfg_sdr_cas  = 3'd2;
    cfg_sdr_rfsh = 12'd100;
    drive(NOP);
    exp_reset_state(1);
    tick();
    reset = 1'b0;

    // ACT before init: early-command error, counter still advances.
    exp_at(1, F_FLAGS, 5'b10000, "early_act_flag");
    exp_at(1, F_ACT,   1,        "early_act_cnt");
    exp_at(1, F_ECNT,  1,        "early_act_ecnt");
    exp_at(1, F_STATE, S_INIT,   "early_act_state");
    step(ACT);
    clr_err = 1'b1;
    exp_at(1, F_FLAGS, 0, "clr1_flags");
    exp_at(1, F_ECNT,  0, "clr1_ecnt");
    step(NOP);
    clr_err = 1'b0;

    // cke low turns a RD encoding into NOP.
    drive(RD);
    bus_if.cke = 1'b0;
    exp_at(1, F_CMD,   NOP, "cke0_cmd");
    exp_at(1, F_RD,    0,   "cke0_rd");
    exp_at(1, F_FLAGS, 0,   "cke0_flags");
    tick();

    // Init: PRE without A10 is ignored, PRE-all then good MRS reaches S_RUN.
    exp_at(1, F_STATE, S_INIT, "pre_noa10_state");
    step(PRE, 13'h000);
    exp_at(1, F_STATE, S_MODE, "pre_all_state");
    exp_at(1, F_CMD,   PRE,    "pre_all_cmd");
    step(PRE, 13'h400);
    exp_at(1, F_STATE, S_RUN,  "mrs_ok_state");
    exp_at(1, F_FLAGS, 0,      "mrs_ok_flags");
    step(MRS, 13'h020);

    // Re-init MRS with CAS 3 against cfg 2.
    exp_at(1, F_STATE, S_MODE,   "mrs_bad_state");
    exp_at(1, F_FLAGS, 5'b01000, "mrs_bad_flags");
    exp_at(1, F_ECNT,  1,        "mrs_bad_ecnt");
    step(MRS, 13'h030);
    clr_err = 1'b1;
    exp_at(1, F_FLAGS, 0, "clr2_flags");
    exp_at(1, F_ECNT,  0, "clr2_ecnt");
    step(NOP);
    clr_err = 1'b0;
    exp_at(1, F_STATE, S_RUN, "mrs_ok2_state");
    step(MRS, 13'h020);

    exp_at(1, F_REF, 1, "ref1_cnt");
    exp_at(1, F_GAP, 0, "ref1_gap");
    exp_at(2, F_GAP, 1, "ref1_gap_inc");
    step(REF);

    // Read with CAS 3 answered on time.
    cfg_sdr_cas = 3'd3;
    exp_at(1, F_RD,    1,  "rd1_cnt");
    exp_at(1, F_CMD,   RD, "rd1_cmd");
    exp_at(4, F_FLAGS, 0,  "rd1_ontime_flags");
    exp_at(4, F_ECNT,  0,  "rd1_ontime_ecnt");
    exp_at(5, F_FLAGS, 0,  "rd1_after_flags");
    step(RD);
    step(NOP);
    step(NOP);
    step(NOP, 13'h000, 1'b1);
    step(NOP);

    // Read never answered.
    exp_at(1, F_RD,    2,        "rd2_cnt");
    exp_at(3, F_FLAGS, 0,        "rd2_pending_flags");
    exp_at(4, F_FLAGS, 5'b00001, "rd2_miss_flags");
    exp_at(4, F_ECNT,  1,        "rd2_miss_ecnt");
    step(RD);
    step(NOP);
    step(NOP);
    step(NOP);

    // Spurious data in the same cycle as clr_err: the new error survives.
    clr_err = 1'b1;
    exp_at(1, F_FLAGS, 5'b00010, "spur_flags");
    exp_at(1, F_ECNT,  1,        "spur_ecnt");
    step(NOP, 13'h000, 1'b1);
    clr_err = 1'b0;
    step(NOP);

    // Refresh overdue at gap = 100 + 64 + 1, counted once.
    clr_err = 1'b1;
    exp_at(1,   F_GAP,   0,        "ref2_gap");
    exp_at(1,   F_REF,   2,        "ref2_cnt");
    exp_at(1,   F_FLAGS, 0,        "ref2_flags");
    exp_at(165, F_GAP,   164,      "ovd_pre_gap");
    exp_at(165, F_FLAGS, 0,        "ovd_pre_flags");
    exp_at(166, F_GAP,   165,      "ovd_gap");
    exp_at(166, F_FLAGS, 5'b00100, "ovd_flags");
    exp_at(166, F_ECNT,  1,        "ovd_ecnt");
    exp_at(168, F_GAP,   167,      "ovd_late_gap");
    exp_at(168, F_ECNT,  1,        "ovd_no_recount");
    step(REF);
    clr_err = 1'b0;
    for (int i = 0; i < 167; i++) step(NOP);

    drive(NOP);
    bus_if.cke = 1'b0;
    exp_at(1, F_GAP, 167, "cke0_gap_hold");
    tick();
    exp_at(1, F_GAP,   0,        "ref3_gap");
    exp_at(1, F_REF,   3,        "ref3_cnt");
    exp_at(1, F_FLAGS, 5'b00100, "ref3_sticky");
    step(REF);
    exp_at(1, F_ACT,   2,        "run_act_cnt");
    exp_at(1, F_FLAGS, 5'b00100, "run_act_noerr");
    step(ACT);
    exp_at(1, F_WR, 1, "run_wr_cnt");
    step(WR);

    // Reset while a read is pending: no miss after release.
    exp_at(1, F_RD, 3, "rd3_cnt");
    step(RD);
    reset = 1'b1;
    exp_reset_state(1);
    step(NOP);
    reset = 1'b0;
    exp_at(4, F_FLAGS, 0,      "post_rst_flags");
    exp_at(4, F_ECNT,  0,      "post_rst_ecnt");
    exp_at(4, F_STATE, S_INIT, "post_rst_state");
    for (int i = 0; i < 4; i++) step(NOP);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
